// File: rtl/decimal_seq_multiplier.sv
// decimal_seq_multiplier
//   Sequential BCD mantissa multiplier. It processes one multiplier digit per
//   cycle, least significant digit first. It returns the 2*NDIG-digit BCD
//   product and the raw (unbiased) exponent sum. Valid/ready handshakes are
//   used on both sides, and only one operation is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   E1/E2/M1/M2 valid
//   in_ready   block idle, operands will be accepted
//   E1, E2     operand exponents (EW bits)
//   M1         multiplicand, NDIG BCD digits
//   M2         multiplier, NDIG BCD digits
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   P          product, 2*NDIG BCD digits
//   E_out      E1+E2, EW+1 bits, no bias removal
//   err        a nibble > 9 was present in M1 or M2 at accept
module decimal_seq_multiplier #(
    parameter int NDIG = 7,
    parameter int EW   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EW-1:0]       E1,
    input  logic [EW-1:0]       E2,
    input  logic [4*NDIG-1:0]   M1,
    input  logic [4*NDIG-1:0]   M2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NDIG-1:0]   P,
    output logic [EW:0]         E_out,
    output logic                err
);

    localparam int MW = 4 * NDIG;        // mantissa width
    localparam int AW = 4 * (NDIG + 1);  // one extra digit for multiples / accumulator
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [MW-1:0] m1_r;
    logic [MW-1:0] m2_r;
    logic [AW-1:0] mul2_r;
    logic [AW-1:0] mul4_r;
    logic [AW-1:0] mul5_r;
    logic [AW-1:0] acc;
    logic [MW-1:0] plo;
    logic [CW-1:0] cnt;

    // Digit-wise BCD doubling. Invalid input nibbles produce don't-care output.
    function automatic logic [AW-1:0] bcd_dbl(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        logic          c;
        logic [4:0]    t;
        r = '0;
        c = 1'b0;
        for (int unsigned i = 0; i < NDIG + 1; i++) begin
            t = {a[4*i +: 4], 1'b0} + {4'd0, c};
            if (t > 5'd9) begin
                t = t - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = t[3:0];
        end
        return r;
    endfunction

    // Ripple BCD addition. The carry out of the top digit is dropped;
    // operand ranges guarantee that it never occurs for valid BCD.
    function automatic logic [AW-1:0] bcd_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b);
        logic [AW-1:0] r;
        logic          c;
        logic [4:0]    t;
        r = '0;
        c = 1'b0;
        for (int unsigned i = 0; i < NDIG + 1; i++) begin
            t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (t > 5'd9) begin
                t = t + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = t[3:0];
        end
        return r;
    endfunction

    function automatic logic has_bad_digit(input logic [MW-1:0] m);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (m[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Multiples of M1 that are registered during PRE.
    logic [AW-1:0] m1x;
    logic [AW-1:0] pre2;
    logic [AW-1:0] pre4;
    logic [AW-1:0] pre5;

    always_comb begin
        m1x  = {4'h0, m1_r};
        pre2 = bcd_dbl(m1x);
        pre4 = bcd_dbl(pre2);
        pre5 = bcd_add(pre4, m1x);
    end

    // Partial-product step. m2_r is shifted right each MUL cycle, so its
    // low nibble is always digit cnt of the original M2.
    logic [3:0]    dig;
    logic [AW-1:0] opx;
    logic [AW-1:0] opy;
    logic [AW-1:0] s;

    always_comb begin
        dig = m2_r[3:0];
        opx = '0;
        opy = '0;
        case (dig)
            4'd1: opx = m1x;
            4'd2: opx = mul2_r;
            4'd3: begin opx = m1x;    opy = mul2_r; end
            4'd4: opx = mul4_r;
            4'd5: opx = mul5_r;
            4'd6: begin opx = mul2_r; opy = mul4_r; end
            4'd7: begin opx = mul2_r; opy = mul5_r; end
            4'd8: begin opx = mul4_r; opy = mul4_r; end
            4'd9: begin opx = mul4_r; opy = mul5_r; end
            default: begin opx = '0;  opy = '0;     end
        endcase
        s = bcd_add(bcd_add(acc, opx), opy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            P         <= '0;
            E_out     <= '0;
            err       <= 1'b0;
            m1_r      <= '0;
            m2_r      <= '0;
            mul2_r    <= '0;
            mul4_r    <= '0;
            mul5_r    <= '0;
            acc       <= '0;
            plo       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        m1_r     <= M1;
                        m2_r     <= M2;
                        E_out    <= {1'b0, E1} + {1'b0, E2};
                        err      <= has_bad_digit(M1) | has_bad_digit(M2);
                        acc      <= '0;
                        plo      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_PRE;
                    end
                end
                S_PRE: begin
                    mul2_r <= pre2;
                    mul4_r <= pre4;
                    mul5_r <= pre5;
                    state  <= S_MUL;
                end
                S_MUL: begin
                    plo  <= {s[3:0], plo[MW-1:4]};
                    acc  <= {4'h0, s[AW-1:4]};
                    m2_r <= m2_r >> 4;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The first DONE cycle loads P from the finished accumulator.
                    // out_valid then holds until the handshake completes.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        P         <= {acc[MW-1:0], plo};
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
